// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic [1:0]  GRANT_HOST         = 2'b01;
  localparam logic [1:0]  GRANT_CORE         = 2'b10;
  localparam logic [31:0] DEFAULT_ERROR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/memory_arbiter.sv
// Serialises host and core accesses onto a single memory port, one outstanding
// access at a time, with a response watchdog that forces an error completion.
//
// state | meaning
// IDLE  | no transaction; sample requests and pick a winner
// WAIT  | memory access issued, waiting for mem_resp or watchdog expiry
// DONE  | completion pulse on the winner's side; requests ignored
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                    BUS_WIDTH      = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    HOST_PRIORITY  = 1,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERROR_WORD     = DATA_WIDTH'(DEFAULT_ERROR_WORD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [BUS_WIDTH-1:0]  host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_resp,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [BUS_WIDTH-1:0]  core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_resp,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [1:0]            grant,
  output logic                  timeout_err,
  input  logic                  err_clear
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t            state, state_nxt;
  logic [1:0]            last_grant, last_grant_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  mem_req_nxt, mem_we_nxt;
  logic [BUS_WIDTH-1:0]  mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic [1:0]            grant_nxt;
  logic                  host_resp_nxt, core_resp_nxt;
  logic [DATA_WIDTH-1:0] host_rdata_nxt, core_rdata_nxt;
  logic                  timeout_err_nxt;
  logic [1:0]            win;
  logic [DATA_WIDTH-1:0] resp_data;

  function automatic logic [1:0] pick_winner(input logic h, input logic c, input logic last_core);
    if (h && c) begin
      if (HOST_PRIORITY != 0) return GRANT_HOST;
      return last_core ? GRANT_HOST : GRANT_CORE;
    end
    if (h) return GRANT_HOST;
    if (c) return GRANT_CORE;
    return 2'b00;
  endfunction

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    cnt_nxt         = cnt;
    mem_req_nxt     = 1'b0;
    mem_we_nxt      = mem_we;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    grant_nxt       = grant;
    host_resp_nxt   = 1'b0;
    core_resp_nxt   = 1'b0;
    host_rdata_nxt  = host_rdata;
    core_rdata_nxt  = core_rdata;
    timeout_err_nxt = timeout_err;
    win             = pick_winner(host_req, core_req, last_grant == GRANT_CORE);
    resp_data       = mem_resp ? mem_rdata : ERROR_WORD;

    case (state)
      IDLE: begin
        if (win != 2'b00) begin
          state_nxt      = WAIT;
          mem_req_nxt    = 1'b1;
          grant_nxt      = win;
          last_grant_nxt = win;
          cnt_nxt        = '0;
          if (win == GRANT_HOST) begin
            mem_we_nxt    = host_we;
            mem_addr_nxt  = host_addr;
            mem_wdata_nxt = host_wdata;
          end else begin
            mem_we_nxt    = core_we;
            mem_addr_nxt  = core_addr;
            mem_wdata_nxt = core_wdata;
          end
        end
      end
      WAIT: begin
        if (mem_resp || (cnt == CNT_LAST)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          if (!mem_resp) timeout_err_nxt = 1'b1;
          if (grant == GRANT_HOST) begin
            host_resp_nxt  = 1'b1;
            host_rdata_nxt = resp_data;
          end else begin
            core_resp_nxt  = 1'b1;
            core_rdata_nxt = resp_data;
          end
        end else if (!mem_req) begin
          // the watchdog counts the cycles that follow the request pulse
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (err_clear) timeout_err_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= GRANT_CORE;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      grant       <= 2'b00;
      host_resp   <= 1'b0;
      core_resp   <= 1'b0;
      host_rdata  <= '0;
      core_rdata  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      cnt         <= cnt_nxt;
      mem_req     <= mem_req_nxt;
      mem_we      <= mem_we_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      grant       <= grant_nxt;
      host_resp   <= host_resp_nxt;
      core_resp   <= core_resp_nxt;
      host_rdata  <= host_rdata_nxt;
      core_rdata  <= core_rdata_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: instance 0 uses host priority, instance 1 round-robin.
module tb_memory_arbiter;
  import mem_arb_pkg::*;

  localparam int BW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int N  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req   [N][2];
  logic          we    [N][2];
  logic [BW-1:0] addr  [N][2];
  logic [DW-1:0] wdata [N][2];
  logic [DW-1:0] host_rdata [N];
  logic [DW-1:0] core_rdata [N];
  logic          host_resp  [N];
  logic          core_resp  [N];
  logic          mem_req    [N];
  logic          mem_we     [N];
  logic [BW-1:0] mem_addr   [N];
  logic [DW-1:0] mem_wdata  [N];
  logic [DW-1:0] mem_rdata  [N];
  logic          mem_resp   [N];
  logic [1:0]    grant      [N];
  logic          timeout_err[N];
  logic          err_clear  [N];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q [N][2][$];
  logic [1:0]    grant_log [N][$];
  int            hang [N];
  int            dly_fix [N];
  int            last_w [N];
  int            owner [N];
  logic          te_m [N];
  logic          mreq_prev [N];
  logic          zero_chk [N];
  logic [1:0]    snap [N];

  function automatic logic [DW-1:0] mem_fn(input logic [BW-1:0] a);
    return 32'hCAFE_0000 ^ (a >> 4);
  endfunction

  function automatic logic resp_of(input int d, input int r);
    return (r == 0) ? host_resp[d] : core_resp[d];
  endfunction

  function automatic logic [DW-1:0] rdata_of(input int d, input int r);
    return (r == 0) ? host_rdata[d] : core_rdata[d];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference winner: single requester wins; ties go to host or alternate.
  task automatic monitor(input int d);
    int w;
    logic [DW-1:0] e;
    if (!reset) begin
      mreq_prev[d] = 1'b0;
      zero_chk[d]  = 1'b0;
      return;
    end
    if (zero_chk[d]) begin
      check($sformatf("grant_clear d%0d", d), grant[d], 2'b00);
      check($sformatf("resp_pulse d%0d", d), {host_resp[d], core_resp[d]}, 2'b00);
      zero_chk[d] = 1'b0;
    end
    if (mem_req[d]) begin
      check($sformatf("mem_req_one_cycle d%0d", d), mreq_prev[d], 1'b0);
      if (!mreq_prev[d]) begin
        if (snap[d] == 2'b11) w = (d == 0) ? 0 : ((last_w[d] == 0) ? 1 : 0);
        else if (snap[d] == 2'b01) w = 0;
        else if (snap[d] == 2'b10) w = 1;
        else w = -1;
        if (w < 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_mem_req d%0d: got mem_req=1, want 0 with no request", d);
        end else begin
          check($sformatf("grant d%0d", d), grant[d], (w == 0) ? GRANT_HOST : GRANT_CORE);
          check($sformatf("mem_addr d%0d", d), mem_addr[d], addr[d][w]);
          check($sformatf("mem_we d%0d", d), mem_we[d], we[d][w]);
          check($sformatf("mem_wdata d%0d", d), mem_wdata[d], wdata[d][w]);
          owner[d]  = w;
          last_w[d] = w;
        end
        grant_log[d].push_back(grant[d]);
      end
    end
    mreq_prev[d] = mem_req[d];
    for (int r = 0; r < 2; r++) begin
      if (resp_of(d, r)) begin
        if (hang[d] != 0) te_m[d] = 1'b1;
        if (exp_q[d][r].size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp d%0d r%0d: got resp=1, want 0", d, r);
        end else begin
          e = exp_q[d][r].pop_front();
          check($sformatf("rdata d%0d r%0d", d, r), rdata_of(d, r), e);
        end
        check($sformatf("resp_owner d%0d", d), r, owner[d]);
        check($sformatf("grant_at_resp d%0d", d), grant[d], (r == 0) ? GRANT_HOST : GRANT_CORE);
        check($sformatf("timeout_err d%0d", d), timeout_err[d], te_m[d]);
        zero_chk[d] = 1'b1;
      end
    end
  endtask

  task automatic mem_respond(input int d);
    int dly;
    dly = (dly_fix[d] >= 0) ? dly_fix[d] : int'($urandom_range(0, 3));
    if (dly > 0) begin
      repeat (dly) @(posedge clk);
      #1;
    end
    mem_resp[d]  = 1'b1;
    mem_rdata[d] = mem_fn(mem_addr[d]);
    @(posedge clk); #1;
    if ($urandom_range(0, 3) == 0) begin
      mem_rdata[d] = 32'h0BAD_0BAD;
      @(posedge clk); #1;
    end
    mem_resp[d] = 1'b0;
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    memory_arbiter #(
      .BUS_WIDTH(BW), .DATA_WIDTH(DW), .HOST_PRIORITY((g == 0) ? 1 : 0),
      .TIMEOUT_CYCLES(TO), .ERROR_WORD(32'hDEAD_BEEF)
    ) u_dut (
      .clk(clk), .reset(reset),
      .host_req(req[g][0]), .host_we(we[g][0]), .host_addr(addr[g][0]), .host_wdata(wdata[g][0]),
      .host_rdata(host_rdata[g]), .host_resp(host_resp[g]),
      .core_req(req[g][1]), .core_we(we[g][1]), .core_addr(addr[g][1]), .core_wdata(wdata[g][1]),
      .core_rdata(core_rdata[g]), .core_resp(core_resp[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .mem_resp(mem_resp[g]),
      .grant(grant[g]), .timeout_err(timeout_err[g]), .err_clear(err_clear[g])
    );

    always @(posedge clk) snap[g] = {req[g][1], req[g][0]};
    always @(negedge clk) monitor(g);
    always begin
      @(negedge clk);
      if (reset && mem_req[g] && hang[g] == 0) mem_respond(g);
    end
  end

  task automatic do_txn(input int d, input int r, input logic w, input logic [BW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] ex, output int lat);
    @(posedge clk); #1;
    we[d][r] = w; addr[d][r] = a; wdata[d][r] = wd; req[d][r] = 1'b1;
    exp_q[d][r].push_back(ex);
    lat = 0;
    forever begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (resp_of(d, r)) break;
      if (lat >= 200) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_wait d%0d r%0d: got no resp after %0d cycles, want resp", d, r, lat);
        break;
      end
    end
    req[d][r] = 1'b0;
  endtask

  task automatic rand_agent(input int d, input int r, input int n);
    int lat;
    logic [BW-1:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      a = $urandom & 32'h0000_FFFC;
      do_txn(d, r, 1'($urandom_range(0, 1)), a, $urandom, mem_fn(a), lat);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < N; d++) begin
      check({tag, "_mem_req"}, mem_req[d], 1'b0);
      check({tag, "_grant"}, grant[d], 2'b00);
      check({tag, "_resp"}, {host_resp[d], core_resp[d]}, 2'b00);
      check({tag, "_timeout_err"}, timeout_err[d], 1'b0);
      check({tag, "_mem_addr"}, mem_addr[d], '0);
      check({tag, "_rdata"}, {host_rdata[d], core_rdata[d]}, '0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int lat, lat2;
    logic [1:0] seq [4];
    for (int d = 0; d < N; d++) begin
      hang[d] = 0; dly_fix[d] = -1; last_w[d] = 1; owner[d] = 0; te_m[d] = 1'b0;
      mreq_prev[d] = 1'b0; zero_chk[d] = 1'b0; err_clear[d] = 1'b0;
      mem_resp[d] = 1'b0; mem_rdata[d] = '0;
      for (int r = 0; r < 2; r++) begin
        req[d][r] = 1'b0; we[d][r] = 1'b0; addr[d][r] = '0; wdata[d][r] = '0;
      end
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(posedge clk); #1 reset = 1'b1;

    // host read, memory answers one cycle after the request pulse
    dly_fix[0] = 1;
    do_txn(0, 0, 1'b0, 32'h10, '0, 32'hCAFE_0001, lat);
    check("t1_latency", lat, 3);

    // simultaneous requests under host priority
    dly_fix[0] = 0;
    grant_log[0].delete();
    fork
      do_txn(0, 0, 1'b0, 32'h100, '0, mem_fn(32'h100), lat);
      do_txn(0, 1, 1'b0, 32'h300, '0, mem_fn(32'h300), lat2);
    join
    seq[0] = GRANT_HOST; seq[1] = GRANT_CORE;
    check("t2_grant_count", grant_log[0].size(), 2);
    for (int i = 0; i < grant_log[0].size() && i < 2; i++) check($sformatf("t2_grant%0d", i), grant_log[0][i], seq[i]);

    // continuous requests under round-robin
    grant_log[1].delete();
    fork
      begin
        do_txn(1, 0, 1'b0, 32'h40, '0, mem_fn(32'h40), lat);
        do_txn(1, 0, 1'b1, 32'h44, 32'h1111, mem_fn(32'h44), lat);
      end
      begin
        do_txn(1, 1, 1'b0, 32'h80, '0, mem_fn(32'h80), lat2);
        do_txn(1, 1, 1'b1, 32'h84, 32'h2222, mem_fn(32'h84), lat2);
      end
    join
    seq[0] = GRANT_HOST; seq[1] = GRANT_CORE; seq[2] = GRANT_HOST; seq[3] = GRANT_CORE;
    check("t3_grant_count", grant_log[1].size(), 4);
    for (int i = 0; i < grant_log[1].size() && i < 4; i++) check($sformatf("t3_grant%0d", i), grant_log[1][i], seq[i]);

    // core write
    dly_fix[0] = 2;
    do_txn(0, 1, 1'b1, 32'h200, 32'h55AA, mem_fn(32'h200), lat);

    // memory never answers: watchdog completion then err_clear
    hang[1] = 1;
    do_txn(1, 1, 1'b0, 32'h400, '0, 32'hDEAD_BEEF, lat);
    check("t5_latency", lat, 10);
    @(posedge clk); #1;
    check("t5_sticky", timeout_err[1], 1'b1);
    err_clear[1] = 1'b1;
    @(posedge clk); #1 err_clear[1] = 1'b0;
    te_m[1] = 1'b0;
    check("t5_cleared", timeout_err[1], 1'b0);
    hang[1] = 0;

    // reset while waiting on memory
    hang[0] = 1;
    @(posedge clk); #1;
    we[0][0] = 1'b0; addr[0][0] = 32'h60; req[0][0] = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("t6_reset");
    req[0][0] = 1'b0;
    for (int d = 0; d < N; d++) begin last_w[d] = 1; te_m[d] = 1'b0; end
    @(posedge clk); #1 reset = 1'b1;
    mem_resp[0] = 1'b1; mem_rdata[0] = 32'h1234_5678;
    @(posedge clk); #1 mem_resp[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_no_resp", {host_resp[0], core_resp[0]}, 2'b00);
    check("t6_no_mem_req", mem_req[0], 1'b0);
    hang[0] = 0; dly_fix[0] = -1;
    do_txn(0, 0, 1'b0, 32'h70, '0, mem_fn(32'h70), lat);

    // randomized traffic on both instances
    fork
      rand_agent(0, 0, 25);
      rand_agent(0, 1, 25);
      rand_agent(1, 0, 25);
      rand_agent(1, 1, 25);
    join
    repeat (4) @(posedge clk);
    for (int d = 0; d < N; d++)
      for (int r = 0; r < 2; r++)
        check($sformatf("drain d%0d r%0d", d, r), exp_q[d][r].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
